// File: rtl/multi_channel_freq_scaler_pkg.sv
// rtl/multi_channel_freq_scaler_pkg.sv - shared constants for the channelised clock divider
// Purpose : reset half-period and config channel-select width, shared with the PWM blocks.
// Ports   : none (package).
package multi_channel_freq_scaler_pkg;

   // 25 input cycles per half-period turns 50 MHz into 1 MHz
   localparam int DEFAULT_HALF_CYC = 25;

   // cfg_ch width; addresses up to 16 channels
   localparam int CFG_CH_W = 4;

endpackage

// File: rtl/freq_scaler_ch.sv
// rtl/freq_scaler_ch.sv - one divider channel with shadowed, boundary-applied half-period
// Purpose : 50%-duty divided clock plus a one-cycle tick on each of its rising edges.
// Ports   : clk, rst_n (async, active low), en (run/hold-low), wr (load shadow),
//           half_in (new half-period), clk_out (divided clock), tick (rising-edge pulse).
module freq_scaler_ch
   import multi_channel_freq_scaler_pkg::*;
#(
   parameter int DIV_W        = 16,
   parameter int DEFAULT_HALF = DEFAULT_HALF_CYC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] half_in,
   output logic             clk_out,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] active;
   logic [DIV_W-1:0] eff;
   logic [DIV_W-1:0] next_active;

   // half-periods of 0 and 1 both mean "toggle every cycle"
   assign eff = (active == '0) ? DIV_W'(1) : active;

   // a write landing on the reload cycle bypasses the shadow so it is not lost for a period
   assign next_active = wr ? half_in : shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         shadow  <= DIV_W'(DEFAULT_HALF);
         active  <= DIV_W'(DEFAULT_HALF);
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         if (wr) begin
            shadow <= half_in;
         end
         if (!en) begin
            // held low and re-armed so restart matches reset-release timing
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= next_active;
         end else if (cnt == eff - DIV_W'(1)) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
            active  <= next_active;
         end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multi_channel_freq_scaler.sv
// rtl/multi_channel_freq_scaler.sv - NUM_CH runtime-programmable clock dividers
// Purpose : decodes config writes to one channel and instantiates NUM_CH divider channels.
// Ports   : clk_50MHz, rst_n (async, active low), en[NUM_CH], cfg_wr, cfg_ch, cfg_half,
//           clk_out[NUM_CH] (divided clocks), tick[NUM_CH] (rising-edge pulses).
module multi_channel_freq_scaler
   import multi_channel_freq_scaler_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DIV_W        = 16,
   parameter int DEFAULT_HALF = DEFAULT_HALF_CYC
) (
   input  logic                clk_50MHz,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   en,
   input  logic                cfg_wr,
   input  logic [CFG_CH_W-1:0] cfg_ch,
   input  logic [DIV_W-1:0]    cfg_half,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick
);

   logic [NUM_CH-1:0] wr;

   // out-of-range cfg_ch matches no channel, so the write is silently dropped
   always_comb begin
      wr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_wr && (cfg_ch == CFG_CH_W'(i))) begin
            wr[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      freq_scaler_ch #(
         .DIV_W        (DIV_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
         .clk     (clk_50MHz),
         .rst_n   (rst_n),
         .en      (en[g]),
         .wr      (wr[g]),
         .half_in (cfg_half),
         .clk_out (clk_out[g]),
         .tick    (tick[g])
      );
   end

endmodule

// File: tb/tb_multi_channel_freq_scaler.sv
// tb/tb_multi_channel_freq_scaler.sv - scoreboard bench for multi_channel_freq_scaler
// Purpose : drives directed and random traffic; a schedule-based model predicts outputs.
// Ports   : none (top-level bench).
module tb_multi_channel_freq_scaler;

   logic        clk_50MHz = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic        cfg_wr;
   logic [3:0]  cfg_ch;
   logic [15:0] cfg_half;
   logic [3:0]  clk_out;
   logic [3:0]  tick;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];

   // model: absolute edge index of each channel's next toggle
   int t;
   int m_shadow[4];
   int m_active[4];
   int m_next[4];
   bit m_run[4];
   bit m_lvl[4];

   always #10 clk_50MHz = ~clk_50MHz;

   multi_channel_freq_scaler #(
      .NUM_CH       (4),
      .DIV_W        (16),
      .DEFAULT_HALF (25)
   ) dut (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_half  (cfg_half),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   function automatic int eff_of(input int a);
      return (a == 0) ? 1 : a;
   endfunction

   task automatic model_reset();
      t = 0;
      for (int c = 0; c < 4; c++) begin
         m_shadow[c] = 25;
         m_active[c] = 25;
         m_next[c]   = 0;
         m_run[c]    = 1'b0;
         m_lvl[c]    = 1'b0;
      end
   endtask

   // drive one cycle of inputs, predict the outputs after the next edge, advance one edge
   task automatic step(input logic [3:0] e, input logic w, input logic [3:0] ch, input int h);
      logic [3:0] ec;
      logic [3:0] et;
      bit wc;
      en       = e;
      cfg_wr   = w;
      cfg_ch   = ch;
      cfg_half = h[15:0];
      t++;
      for (int c = 0; c < 4; c++) begin
         wc    = w && (int'(ch) == c);
         et[c] = 1'b0;
         if (!e[c]) begin
            m_run[c]    = 1'b0;
            m_lvl[c]    = 1'b0;
            m_active[c] = wc ? h : m_shadow[c];
         end else begin
            if (!m_run[c]) begin
               m_run[c]  = 1'b1;
               m_next[c] = t + eff_of(m_active[c]) - 1;
            end
            if (t == m_next[c]) begin
               m_lvl[c]    = !m_lvl[c];
               et[c]       = m_lvl[c];
               m_active[c] = wc ? h : m_shadow[c];
               m_next[c]   = t + eff_of(m_active[c]);
            end
         end
         if (wc) m_shadow[c] = h;
         ec[c] = m_lvl[c];
      end
      exp_q.push_back({ec, et});
      @(posedge clk_50MHz);
      #1;
   endtask

   // monitor: one expected sample per edge, compared on the falling edge
   int         mon_n = 0;
   logic [7:0] mon_exp;
   initial begin
      forever begin
         @(negedge clk_50MHz);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_n++;
            tests++;
            if ({clk_out, tick} !== mon_exp) begin
               fails++;
               $display("FAIL scoreboard sample %0d: clk_out/tick got %b/%b expected %b/%b",
                        mon_n, clk_out, tick, mon_exp[7:4], mon_exp[3:0]);
            end
         end
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  guard;
      logic [3:0] ren;
      rst_n    = 1'b0;
      en       = '0;
      cfg_wr   = 1'b0;
      cfg_ch   = '0;
      cfg_half = '0;
      model_reset();
      repeat (3) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      tests++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         fails++;
         $display("FAIL reset_state: clk_out/tick got %b/%b expected 0000/0000", clk_out, tick);
      end
      #1 rst_n = 1'b1;

      // defaults on all channels, ch1 reprogrammed to 5 at cycle 10
      for (int i = 1; i <= 100; i++) step(4'hF, i == 10, 4'd1, 5);

      // half 0 and 1 written while disabled, then enabled
      step(4'b0011, 1'b1, 4'd2, 0);
      step(4'b0011, 1'b1, 4'd3, 1);
      step(4'b0011, 1'b0, 4'd0, 0);
      repeat (20) step(4'hF, 1'b0, 4'd0, 0);

      // drop en[0] while its clock is high, then re-enable
      guard = 0;
      while (!m_lvl[0] && guard < 200) begin
         step(4'hF, 1'b0, 4'd0, 0);
         guard++;
      end
      tests++;
      if (!m_lvl[0]) begin
         fails++;
         $display("FAIL en_drop_setup: ch0 high phase got none expected within 200 cycles");
      end
      repeat (3) step(4'b1110, 1'b0, 4'd0, 0);
      repeat (60) step(4'hF, 1'b0, 4'd0, 0);

      // write ch1 exactly on its boundary cycle, then an out-of-range write
      guard = 0;
      while (!(m_run[1] && m_next[1] == t + 1) && guard < 200) begin
         step(4'hF, 1'b0, 4'd0, 0);
         guard++;
      end
      tests++;
      if (!(m_run[1] && m_next[1] == t + 1)) begin
         fails++;
         $display("FAIL boundary_setup: ch1 boundary got none expected within 200 cycles");
      end
      step(4'hF, 1'b1, 4'd1, 3);
      repeat (20) step(4'hF, 1'b0, 4'd0, 0);
      for (int i = 0; i < 40; i++) step(4'hF, i < 4, 4'd7, 2);

      // asynchronous reset pulse between edges
      @(negedge clk_50MHz);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         fails++;
         $display("FAIL async_reset: clk_out/tick got %b/%b expected 0000/0000", clk_out, tick);
      end
      model_reset();
      @(negedge clk_50MHz);
      #1 rst_n = 1'b1;
      repeat (60) step(4'hF, 1'b0, 4'd0, 0);

      // random traffic: enables flip occasionally, writes include out-of-range channels
      ren = 4'hF;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 29) == 0) ren[c] = ~ren[c];
         end
         step(ren, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 7)),
              int'($urandom_range(0, 9)));
      end

      @(negedge clk_50MHz);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
